nrs_cinit_gen_tx: RTL

Per-OFDM-symbol c_init generator for the NB-IoT NRS value-generator TX chain.
- It sits directly downstream of slot_counter_tx. It pulses that block's cinit_run, samples the slot, first_run and last_run it returns, and tracks the NRS symbol index l ∈ {5,6}.
- It computes c_init = 2^10·(7·(ns+1)+l+1)·(2·N_ID+1) + 2·N_ID + 1 with a sequential shift-add multiplier.
- It hands c_init, with frame/subframe tags, to the Gold-sequence generator.

---
 rtl/nrs_tx_pkg.sv | 31 +++
 rtl/nrs_shift_add_mul.sv | 62 ++++++
 rtl/nrs_cinit_gen_tx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/nrs_tx_pkg.sv
// Shared definitions for the NB-IoT NRS TX c_init path.
// Holds field widths, NRS symbol constants, FSM state encoding and the
// helper that forms the slot/symbol multiplicand A.
package nrs_tx_pkg;

    localparam int unsigned SLOTS_PER_FRAME = 20;
    localparam int unsigned SLOT_W          = $clog2(SLOTS_PER_FRAME);
    localparam int unsigned CELL_W          = 9;
    localparam int unsigned MUL_W           = CELL_W + 1;
    localparam int unsigned CINIT_W         = 31;
    localparam int unsigned NRS_L_BASE      = 5;
    localparam int unsigned A_W             = 8;
    localparam int unsigned PROD_W          = A_W + MUL_W;
    localparam int unsigned IDX_W           = $clog2(MUL_W);
    localparam int unsigned CINIT_SHIFT     = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_CAPT = 3'd2,
        ST_MUL  = 3'd3,
        ST_DONE = 3'd4
    } nrs_state_e;

    // A = 7*(ns+1) + l + 1 with l = NRS_L_BASE + sym_odd; max 147 fits in A_W
    function automatic logic [A_W-1:0] nrs_a_operand(input logic [SLOT_W-1:0] slot,
                                                     input logic              sym_odd);
        return A_W'(7 * (int'(slot) + 1) + int'(NRS_L_BASE) + 1 + int'(sym_odd));
    endfunction

endpackage

// File: rtl/nrs_shift_add_mul.sv
// LSB-first sequential shift-add multiplier, A_W x MUL_W, one bit per cycle.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   start        load operands and clear accumulator
//   a, b         multiplicand / multiplier
//   done_c       high during the cycle whose edge performs the last iteration
//   product_c    accumulator value after this cycle's iteration
module nrs_shift_add_mul
    import nrs_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [A_W-1:0]    a,
    input  logic [MUL_W-1:0]  b,
    output logic              done_c,
    output logic [PROD_W-1:0] product_c
);

    logic [A_W-1:0]    a_q;
    logic [MUL_W-1:0]  b_q;
    logic [PROD_W-1:0] acc_q;
    logic [IDX_W-1:0]  idx_q;
    logic              run_q;
    logic [PROD_W-1:0] addend;

    // Partial product for the current multiplier bit
    always_comb begin
        addend = '0;
        if (b_q[0]) begin
            addend = PROD_W'(a_q) << idx_q;
        end
    end

    assign product_c = acc_q + addend;
    assign done_c    = run_q && (idx_q == IDX_W'(MUL_W - 1));

    // Operand load and iteration state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            idx_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            idx_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            acc_q <= product_c;
            b_q   <= b_q >> 1;
            idx_q <= idx_q + IDX_W'(1);
            if (done_c) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/nrs_cinit_gen_tx.sv
// Per-OFDM-symbol c_init generator for the NB-IoT NRS TX chain.
// Requests a slot advance from slot_counter_tx, captures slot/frame tags,
// tracks NRS symbol l in {5,6}, and computes
//   c_init = 2^10*(7*(ns+1)+l+1)*(2*N_ID+1) + 2*N_ID + 1
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req                      next c_init request (sampled in IDLE only)
//   ncell_id                 physical cell ID, latched in CAPT
//   slot_in, first_run_in,
//   last_run_in              slot counter outputs
//   cinit_run                one-cycle advance pulse to slot counter
//   cinit, cinit_valid       result and its one-cycle strobe
//   first_run_out,
//   last_run_out             tags aligned with cinit
//   busy                     high whenever not IDLE
module nrs_cinit_gen_tx
    import nrs_tx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [CELL_W-1:0]  ncell_id,
    input  logic [SLOT_W-1:0]  slot_in,
    input  logic               first_run_in,
    input  logic               last_run_in,
    output logic               cinit_run,
    output logic [CINIT_W-1:0] cinit,
    output logic               cinit_valid,
    output logic               first_run_out,
    output logic               last_run_out,
    output logic               busy
);

    nrs_state_e        state;
    logic              sym_odd;
    logic              first_q;
    logic              last_q;
    logic [MUL_W-1:0]  b_orig;

    logic              sym_eff_c;
    logic              mul_start_c;
    logic [A_W-1:0]    mul_a_c;
    logic [MUL_W-1:0]  mul_b_c;
    logic              mul_done_c;
    logic [PROD_W-1:0] mul_product_c;

    // Frame start resyncs the symbol parity to l = 5
    assign sym_eff_c   = first_run_in ? 1'b0 : sym_odd;
    assign mul_start_c = (state == ST_CAPT);
    assign mul_a_c     = nrs_a_operand(slot_in, sym_eff_c);
    assign mul_b_c     = {ncell_id, 1'b1};

    nrs_shift_add_mul u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start_c),
        .a         (mul_a_c),
        .b         (mul_b_c),
        .done_c    (mul_done_c),
        .product_c (mul_product_c)
    );

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            sym_odd       <= 1'b0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
            b_orig        <= '0;
            cinit_run     <= 1'b0;
            cinit         <= '0;
            cinit_valid   <= 1'b0;
            first_run_out <= 1'b0;
            last_run_out  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            cinit_run   <= 1'b0;
            cinit_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state     <= ST_RUN;
                        cinit_run <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state <= ST_CAPT;
                end
                ST_CAPT: begin
                    first_q <= first_run_in;
                    last_q  <= last_run_in;
                    sym_odd <= sym_eff_c;
                    b_orig  <= mul_b_c;
                    state   <= ST_MUL;
                end
                ST_MUL: begin
                    // Result is registered on the last iteration edge so that
                    // cinit and cinit_valid appear together in DONE
                    if (mul_done_c) begin
                        cinit         <= (CINIT_W'(mul_product_c) << CINIT_SHIFT)
                                         + CINIT_W'(b_orig);
                        cinit_valid   <= 1'b1;
                        first_run_out <= first_q;
                        last_run_out  <= last_q;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    sym_odd <= ~sym_odd;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
